// File: rtl/calc_pkg.sv
// Shared constants for the calculator controller: display modes, operations
// and the sequencer state encodings.
package calc_pkg;

    localparam logic [1:0] MODE_DEFAULT = 2'd0;
    localparam logic [1:0] MODE_EDIT    = 2'd1;
    localparam logic [1:0] MODE_MEMORY  = 2'd2;
    localparam logic [1:0] MODE_BUSY    = 2'd3;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_EDIT = 3'd1;
    localparam logic [2:0] ST_MEM  = 3'd2;
    localparam logic [2:0] ST_EXEC = 3'd3;
    localparam logic [2:0] ST_WB   = 3'd4;

    function automatic logic [1:0] mode_of(input logic [2:0] st);
        case (st)
            ST_EDIT:        mode_of = MODE_EDIT;
            ST_MEM:         mode_of = MODE_MEMORY;
            ST_EXEC, ST_WB: mode_of = MODE_BUSY;
            default:        mode_of = MODE_DEFAULT;
        endcase
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Cycle counter that bounds how long the sequencer waits for the arithmetic unit.
// expired flags the cycle whose increment would bring the count to TIMEOUT-1.
module seq_watchdog #(
    parameter int TIMEOUT = 64,
    parameter int CW      = $clog2(TIMEOUT)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && !clear && (count == CW'(TIMEOUT - 2));

endmodule

// File: rtl/calc_sequencer.sv
// Calculator controller: mode/operation state, ALU start/done handshake with
// watchdog abort, and the register-bank load strobe.
//
//  state   | meaning
//  IDLE    | default display, waiting for a blip
//  EDIT    | operand being edited, operation chosen
//  MEM     | register bank browsing
//  EXEC    | ALU running, watchdog counting
//  WB      | result valid, load strobe issued on exit
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CW      = $clog2(TIMEOUT)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       UP,
    input  logic       DOWN,
    input  logic       LEFT,
    input  logic       RIGHT,
    input  logic       SELECT,
    input  logic       div_zero,
    input  logic       alu_done,
    input  logic       alu_overflow,
    output logic [1:0] mode,
    output logic [1:0] operation,
    output logic       alu_start,
    output logic       load,
    output logic       ovf,
    output logic       err
);

    logic [2:0] state, state_next;
    logic [1:0] op_next;
    logic       ovf_next, err_next, start_next, load_next;
    logic       wd_clear, wd_expired;

    seq_watchdog #(.TIMEOUT(TIMEOUT), .CW(CW)) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .enable  (state == ST_EXEC),
        .expired (wd_expired)
    );

    always_comb begin
        state_next = state;
        op_next    = operation;
        ovf_next   = ovf;
        err_next   = err;
        start_next = 1'b0;
        load_next  = 1'b0;
        wd_clear   = 1'b0;
        case (state)
            ST_IDLE: begin
                // Entering an operation clears the sticky status flags.
                if (SELECT) begin
                    state_next = ST_MEM;
                end else if (RIGHT || LEFT || UP || DOWN) begin
                    state_next = ST_EDIT;
                    ovf_next   = 1'b0;
                    err_next   = 1'b0;
                    if (RIGHT)     op_next = OP_ADD;
                    else if (LEFT) op_next = OP_SUB;
                    else if (UP)   op_next = OP_MUL;
                    else           op_next = OP_DIV;
                end
            end
            ST_EDIT: begin
                if (SELECT) begin
                    if (operation == OP_DIV && div_zero) begin
                        state_next = ST_IDLE;
                        err_next   = 1'b1;
                    end else begin
                        state_next = ST_EXEC;
                        start_next = 1'b1;
                        wd_clear   = 1'b1;
                    end
                end
            end
            ST_MEM: begin
                if (SELECT) state_next = ST_IDLE;
            end
            ST_EXEC: begin
                // A done coincident with the start pulse is stale; done beats timeout.
                if (alu_done && !alu_start) begin
                    state_next = ST_WB;
                    ovf_next   = alu_overflow;
                end else if (wd_expired) begin
                    state_next = ST_IDLE;
                    err_next   = 1'b1;
                end
            end
            ST_WB: begin
                state_next = ST_IDLE;
                load_next  = 1'b1;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            mode      <= MODE_DEFAULT;
            operation <= OP_ADD;
            alu_start <= 1'b0;
            load      <= 1'b0;
            ovf       <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_next;
            mode      <= mode_of(state_next);
            operation <= op_next;
            alu_start <= start_next;
            load      <= load_next;
            ovf       <= ovf_next;
            err       <= err_next;
        end
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer with TIMEOUT=8 and hand-computed expectations.
`timescale 1ns/1ps
module tb_calc_sequencer;

    localparam int TIMEOUT = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       UP = 1'b0, DOWN = 1'b0, LEFT = 1'b0, RIGHT = 1'b0, SELECT = 1'b0;
    logic       div_zero = 1'b0, alu_done = 1'b0, alu_overflow = 1'b0;
    logic [1:0] mode, operation;
    logic       alu_start, load, ovf, err;

    int n_checks = 0;
    int n_errors = 0;
    int n_start  = 0;
    int n_load   = 0;
    int base_start, base_load;

    calc_sequencer #(.TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .UP           (UP),
        .DOWN         (DOWN),
        .LEFT         (LEFT),
        .RIGHT        (RIGHT),
        .SELECT       (SELECT),
        .div_zero     (div_zero),
        .alu_done     (alu_done),
        .alu_overflow (alu_overflow),
        .mode         (mode),
        .operation    (operation),
        .alu_start    (alu_start),
        .load         (load),
        .ovf          (ovf),
        .err          (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (alu_start) n_start++;
        if (load)      n_load++;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // b = {SELECT, RIGHT, LEFT, UP, DOWN}
    task automatic blip(input logic [4:0] b);
        {SELECT, RIGHT, LEFT, UP, DOWN} = b;
        tick();
        {SELECT, RIGHT, LEFT, UP, DOWN} = 5'b0;
    endtask

    task automatic mark();
        base_start = n_start;
        base_load  = n_load;
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        check("rst_mode", mode, 0);
        check("rst_op", operation, 0);
        check("rst_start", alu_start, 0);
        check("rst_load", load, 0);
        check("rst_ovf", ovf, 0);
        check("rst_err", err, 0);

        // add: done 5 cycles after start
        mark();
        blip(5'b01000);
        check("add_mode_edit", mode, 1);
        check("add_op", operation, 0);
        blip(5'b10000);
        check("add_mode_busy", mode, 3);
        check("add_start", alu_start, 1);
        repeat (5) tick();
        check("add_still_busy", mode, 3);
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        check("add_wb_mode", mode, 3);
        check("add_wb_noload", load, 0);
        tick();
        check("add_load", load, 1);
        check("add_final_mode", mode, 0);
        check("add_ovf", ovf, 0);
        tick();
        check("add_load_low", load, 0);
        check("add_start_count", n_start - base_start, 1);
        check("add_load_count", n_load - base_load, 1);

        // divide by zero abort, then subtract clears err
        mark();
        blip(5'b00001);
        check("div_op", operation, 3);
        div_zero = 1'b1;
        blip(5'b10000);
        check("div0_mode", mode, 0);
        check("div0_err", err, 1);
        tick();
        check("div0_start_count", n_start - base_start, 0);
        check("div0_load_count", n_load - base_load, 0);
        div_zero = 1'b0;
        blip(5'b00100);
        check("sub_err_clear", err, 0);
        check("sub_op", operation, 1);
        blip(5'b10000);
        repeat (2) tick();
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        tick();
        check("sub_load", load, 1);
        check("sub_mode", mode, 0);

        // multiply with watchdog timeout at start+7
        tick();
        mark();
        blip(5'b00010);
        check("to_op", operation, 2);
        blip(5'b10000);
        repeat (6) tick();
        check("to_busy_at6", mode, 3);
        check("to_err_at6", err, 0);
        tick();
        check("to_idle_at7", mode, 0);
        check("to_err", err, 1);
        tick();
        check("to_load_count", n_load - base_load, 0);

        // RIGHT+SELECT in IDLE: SELECT wins, MEM ignores directions
        mark();
        blip(5'b11000);
        check("mem_mode", mode, 2);
        check("mem_op", operation, 2);
        check("mem_err_sticky", err, 1);
        blip(5'b00100);
        check("mem_dir_ignored", mode, 2);
        blip(5'b10000);
        check("mem_exit_mode", mode, 0);
        check("mem_exit_op", operation, 2);
        tick();
        check("mem_load_count", n_load - base_load, 0);

        // reset during EXEC cycle 3
        mark();
        blip(5'b00100);
        check("rx_op", operation, 1);
        blip(5'b10000);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rx_mode", mode, 0);
        check("rx_op_reset", operation, 0);
        check("rx_start", alu_start, 0);
        check("rx_ovf", ovf, 0);
        check("rx_err", err, 0);
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        tick();
        check("rx_mode_after", mode, 0);
        check("rx_load_count", n_load - base_load, 0);

        // multiply with overflow; stale done and blips during EXEC ignored
        mark();
        blip(5'b00010);
        blip(5'b10000);
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        check("ovf_stale_done", mode, 3);
        blip(5'b10100);
        check("ovf_blip_mode", mode, 3);
        check("ovf_blip_op", operation, 2);
        blip(5'b10000);
        check("ovf_blip2_mode", mode, 3);
        alu_done = 1'b1;
        alu_overflow = 1'b1;
        tick();
        alu_done = 1'b0;
        alu_overflow = 1'b0;
        check("ovf_wb_mode", mode, 3);
        tick();
        check("ovf_load", load, 1);
        check("ovf_flag", ovf, 1);
        check("ovf_mode", mode, 0);
        tick();
        check("ovf_load_count", n_load - base_load, 1);

        // done on the timeout edge wins
        blip(5'b01000);
        check("tie_ovf_clear", ovf, 0);
        blip(5'b10000);
        repeat (6) tick();
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        check("tie_wb_mode", mode, 3);
        check("tie_err", err, 0);
        tick();
        check("tie_load", load, 1);
        check("tie_mode", mode, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
